ex_stage: RTL and testbench

Execute stage plus EX/MEM pipeline register of the AZ-Processor core. Consumes the ID/EX register outputs, computes the ALU result and overflow exception, and optionally runs an iterative multiply/divide unit that stalls the front end. It registers everything the MEM stage needs and drives a combinational forwarding path back to the decoder.

---
 rtl/ex_stage_pkg.sv | 66 ++++++
 rtl/ex_stage_if.sv | 46 ++++
 rtl/ex_mdu.sv | 97 +++++++++
 rtl/ex_stage.sv | 149 ++++++++++++++
 tb/tb_ex_stage.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared opcodes, exception codes and EX/MEM bundle types.
// The multiply/divide unit is built only when EX_MDU_EN is defined.
package ex_stage_pkg;

  localparam logic [3:0] ALU_OP_NOP  = 4'd0;
  localparam logic [3:0] ALU_OP_AND  = 4'd1;
  localparam logic [3:0] ALU_OP_OR   = 4'd2;
  localparam logic [3:0] ALU_OP_XOR  = 4'd3;
  localparam logic [3:0] ALU_OP_ADDS = 4'd4;
  localparam logic [3:0] ALU_OP_ADDU = 4'd5;
  localparam logic [3:0] ALU_OP_SUBS = 4'd6;
  localparam logic [3:0] ALU_OP_SUBU = 4'd7;
  localparam logic [3:0] ALU_OP_SHRL = 4'd8;
  localparam logic [3:0] ALU_OP_SHLL = 4'd9;
  localparam logic [3:0] ALU_OP_MUL  = 4'd10;
  localparam logic [3:0] ALU_OP_DIVU = 4'd11;
  localparam logic [3:0] ALU_OP_REMU = 4'd12;

  localparam logic [1:0] MEM_OP_NOP  = 2'd0;
  localparam logic [1:0] CTRL_OP_NOP = 2'd0;

  localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
  localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
  localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
  localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [2:0] ISA_EXP_TRAP       = 3'd5;
  localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'd6;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int MDU_STEPS = 32;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic       en;
    logic       br_flag;
    logic [1:0] mem_op;
    logic [1:0] ctrl_op;
    logic [4:0] dst_addr;
    logic       gpr_we_;
    logic [2:0] exp_code;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    en:       1'b0,
    br_flag:  1'b0,
    mem_op:   MEM_OP_NOP,
    ctrl_op:  CTRL_OP_NOP,
    dst_addr: 5'd0,
    gpr_we_:  DISABLE_,
    exp_code: ISA_EXP_NO_EXP
  };

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_DIVU) ||
           (op == ALU_OP_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage.
// master = surrounding pipeline, slave = ex_stage.
interface ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30
);
  logic [ADDR_W-1:0] id_pc;
  logic              id_en;
  logic [3:0]        id_alu_op;
  logic [DATA_W-1:0] id_alu_in_0;
  logic [DATA_W-1:0] id_alu_in_1;
  logic              id_br_flag;
  logic [1:0]        id_mem_op;
  logic [DATA_W-1:0] id_mem_wr_data;
  logic [1:0]        id_ctrl_op;
  logic [4:0]        id_dst_addr;
  logic              id_gpr_we_;
  logic [2:0]        id_exp_code;

  logic [ADDR_W-1:0] ex_pc;
  logic              ex_en;
  logic              ex_br_flag;
  logic [1:0]        ex_mem_op;
  logic [DATA_W-1:0] ex_mem_wr_data;
  logic [1:0]        ex_ctrl_op;
  logic [4:0]        ex_dst_addr;
  logic              ex_gpr_we_;
  logic [2:0]        ex_exp_code;
  logic [DATA_W-1:0] ex_out;

  modport master (
    output id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1,
    output id_br_flag, id_mem_op, id_mem_wr_data, id_ctrl_op,
    output id_dst_addr, id_gpr_we_, id_exp_code,
    input  ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data,
    input  ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
  );

  modport slave (
    input  id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1,
    input  id_br_flag, id_mem_op, id_mem_wr_data, id_ctrl_op,
    input  id_dst_addr, id_gpr_we_, id_exp_code,
    output ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data,
    output ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
  );
endinterface

// File: rtl/ex_mdu.sv
// Iterative unsigned multiply / divide: one shift-add or
// restoring-divide step per cycle, MDU_STEPS steps per op.
module ex_mdu
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int ACC_W = 2 * DATA_W;
  localparam logic [5:0] LAST = 6'(MDU_STEPS - 1);

  mdu_state_e        state_q;
  logic [5:0]        cnt_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] opnd_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;

  logic [DATA_W:0]   mul_hi;
  logic [ACC_W:0]    div_sh;
  logic [DATA_W:0]   div_top;
  logic [DATA_W-1:0] div_rem;

  // MUL: multiplier in acc low half, shifts right.
  // DIVU/REMU: dividend shifts left, remainder in high half.
  always_comb begin
    mul_hi  = {1'b0, acc_q[ACC_W-1:DATA_W]}
            + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh  = {acc_q, 1'b0};
    div_top = div_sh[ACC_W:DATA_W];
    div_rem = div_top[DATA_W-1:0] - opnd_q;
    acc_d   = div_sh[ACC_W-1:0];
    if (op_q == ALU_OP_MUL) begin
      acc_d = {mul_hi, acc_q[DATA_W-1:1]};
    end else if (div_top >= {1'b0, opnd_q}) begin
      acc_d = {div_rem, div_sh[DATA_W-1:1], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_OP_NOP;
      opnd_q  <= '0;
      acc_q   <= '0;
    end else if (flush) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (start) begin
            state_q <= MDU_RUN;
            cnt_q   <= '0;
            op_q    <= op;
            if (op == ALU_OP_MUL) begin
              opnd_q <= in_0;
              acc_q  <= {{DATA_W{1'b0}}, in_1};
            end else begin
              opnd_q <= in_1;
              acc_q  <= {{DATA_W{1'b0}}, in_0};
            end
          end
        end
        MDU_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST) state_q <= MDU_DONE;
        end
        MDU_DONE: begin
          if (!stall) state_q <= MDU_IDLE;
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign busy = ((state_q == MDU_IDLE) && start) ||
                (state_q == MDU_RUN);
  assign done = (state_q == MDU_DONE);
  assign result = (op_q == ALU_OP_REMU) ? acc_q[ACC_W-1:DATA_W]
                                        : acc_q[DATA_W-1:0];

endmodule

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM register and forwarding output.
// Define EX_MDU_EN to build the iterative MUL/DIVU/REMU unit.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_busy,
  output logic [DATA_W-1:0] ex_fwd_data,
  ex_stage_if.slave         bus
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_out;
  logic              ovf;
  logic              undef;
  logic              mdu_op;

  assign a      = bus.id_alu_in_0;
  assign b      = bus.id_alu_in_1;
  assign sum    = a + b;
  assign diff   = a - b;
  assign mdu_op = is_mdu_op(bus.id_alu_op);

  always_comb begin
    alu_out = '0;
    ovf     = 1'b0;
    case (bus.id_alu_op)
      ALU_OP_AND:  alu_out = a & b;
      ALU_OP_OR:   alu_out = a | b;
      ALU_OP_XOR:  alu_out = a ^ b;
      ALU_OP_ADDS: begin
        alu_out = sum;
        ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      ALU_OP_ADDU: alu_out = sum;
      ALU_OP_SUBS: begin
        alu_out = diff;
        ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      ALU_OP_SUBU: alu_out = diff;
      ALU_OP_SHRL: alu_out = a >> b[4:0];
      ALU_OP_SHLL: alu_out = a << b[4:0];
      default:     alu_out = '0;
    endcase
  end

`ifdef EX_MDU_EN
  logic              mdu_done;
  logic [DATA_W-1:0] mdu_res;

  ex_mdu #(.DATA_W(DATA_W)) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .flush  (flush),
    .start  (bus.id_en && mdu_op),
    .op     (bus.id_alu_op),
    .in_0   (a),
    .in_1   (b),
    .busy   (ex_busy),
    .done   (mdu_done),
    .result (mdu_res)
  );

  assign undef       = 1'b0;
  assign ex_fwd_data = mdu_op ? (mdu_done ? mdu_res : '0)
                              : alu_out;
`else
  assign ex_busy     = 1'b0;
  assign undef       = mdu_op;
  assign ex_fwd_data = alu_out;
`endif

  ex_ctrl_t          ctrl_d, ctrl_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [DATA_W-1:0] wr_d, wr_q;
  logic [DATA_W-1:0] out_d, out_q;

  always_comb begin
    ctrl_d = ctrl_q;
    pc_d   = pc_q;
    wr_d   = wr_q;
    out_d  = out_q;
    if (flush || (!stall && (ex_busy || !bus.id_en))) begin
      ctrl_d = EX_CTRL_BUBBLE;
      pc_d   = '0;
      wr_d   = '0;
      out_d  = '0;
    end else if (!stall) begin
      ctrl_d.en       = 1'b1;
      ctrl_d.br_flag  = bus.id_br_flag;
      ctrl_d.mem_op   = bus.id_mem_op;
      ctrl_d.ctrl_op  = bus.id_ctrl_op;
      ctrl_d.dst_addr = bus.id_dst_addr;
      ctrl_d.gpr_we_  = bus.id_gpr_we_;
      ctrl_d.exp_code = bus.id_exp_code;
      // An exception already raised upstream wins.
      if (bus.id_exp_code == ISA_EXP_NO_EXP) begin
        if (ovf) begin
          ctrl_d.exp_code = ISA_EXP_OVERFLOW;
          ctrl_d.gpr_we_  = DISABLE_;
        end else if (undef) begin
          ctrl_d.exp_code = ISA_EXP_UNDEF_INSN;
          ctrl_d.gpr_we_  = DISABLE_;
        end
      end
      pc_d  = bus.id_pc;
      wr_d  = bus.id_mem_wr_data;
      out_d = ex_fwd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= EX_CTRL_BUBBLE;
      pc_q   <= '0;
      wr_q   <= '0;
      out_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pc_q   <= pc_d;
      wr_q   <= wr_d;
      out_q  <= out_d;
    end
  end

  assign bus.ex_pc          = pc_q;
  assign bus.ex_en          = ctrl_q.en;
  assign bus.ex_br_flag     = ctrl_q.br_flag;
  assign bus.ex_mem_op      = ctrl_q.mem_op;
  assign bus.ex_mem_wr_data = wr_q;
  assign bus.ex_ctrl_op     = ctrl_q.ctrl_op;
  assign bus.ex_dst_addr    = ctrl_q.dst_addr;
  assign bus.ex_gpr_we_     = ctrl_q.gpr_we_;
  assign bus.ex_exp_code    = ctrl_q.exp_code;
  assign bus.ex_out         = out_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// MDU scenarios are selected by EX_MDU_EN.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        ex_busy;
  logic [31:0] fwd;

  int checks = 0;
  int errors = 0;

  ex_stage_if #(.DATA_W(32), .ADDR_W(30)) bus ();

  ex_stage #(.DATA_W(32), .ADDR_W(30)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .ex_busy     (ex_busy),
    .ex_fwd_data (fwd),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    bus.id_en          = 1'b1;
    bus.id_alu_op      = op;
    bus.id_alu_in_0    = x;
    bus.id_alu_in_1    = y;
    bus.id_pc          = 30'h0000_1234;
    bus.id_br_flag     = 1'b1;
    bus.id_mem_op      = 2'd1;
    bus.id_mem_wr_data = 32'hCAFE_F00D;
    bus.id_ctrl_op     = 2'd2;
    bus.id_dst_addr    = 5'd17;
    bus.id_gpr_we_     = 1'b0;
    bus.id_exp_code    = 3'd0;
    #1;
  endtask

  task automatic alu(input string tag, input logic [3:0] op,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] r, input logic [2:0] e,
                     input logic we_);
    drive(op, x, y);
    chk({tag, "_fwd"}, fwd, r);
    tick;
    chk({tag, "_out"}, bus.ex_out, r);
    chk({tag, "_exp"}, 32'(bus.ex_exp_code), 32'(e));
    chk({tag, "_we"}, 32'(bus.ex_gpr_we_), 32'(we_));
  endtask

`ifdef EX_MDU_EN
  task automatic run_mdu(input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, output int lat,
                         output int busy_n, output logic [31:0] fd);
    lat = 0;
    busy_n = 0;
    fd = '0;
    drive(op, x, y);
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      if (ex_busy) busy_n++;
      else fd = fwd;
      tick;
      if (bus.ex_en) lat = n;
    end
    bus.id_en = 1'b0;
    #1;
  endtask

  task automatic mdu(input string tag, input logic [3:0] op,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] r);
    int lat, bn;
    logic [31:0] fd;
    run_mdu(op, x, y, lat, bn, fd);
    chk({tag, "_lat"}, 32'(lat), 32'd34);
    chk({tag, "_busy"}, 32'(bn), 32'd33);
    chk({tag, "_fwd"}, fd, r);
    chk({tag, "_out"}, bus.ex_out, r);
    chk({tag, "_exp"}, 32'(bus.ex_exp_code), 32'd0);
    tick;
  endtask
`endif

  initial begin
    int en_cnt;
    stall = 1'b0;
    flush = 1'b0;
    reset = 1'b1;
    drive(ALU_OP_ADDU, 32'd1, 32'd2);
    tick;
    tick;
    chk("rst_en", 32'(bus.ex_en), 32'd0);
    chk("rst_we", 32'(bus.ex_gpr_we_), 32'd1);
    chk("rst_out", bus.ex_out, 32'd0);
    chk("rst_exp", 32'(bus.ex_exp_code), 32'd0);
    chk("rst_mem", 32'(bus.ex_mem_op), 32'd0);
    chk("rst_busy", 32'(ex_busy), 32'd0);
    reset = 1'b0;

    alu("adds_ovf", ALU_OP_ADDS, 32'h7FFF_FFFF, 32'd1,
        32'h8000_0000, 3'd3, 1'b1);
    chk("adds_en", 32'(bus.ex_en), 32'd1);
    alu("shll", ALU_OP_SHLL, 32'd1, 32'd31, 32'h8000_0000, 3'd0, 1'b0);
    chk("pt_pc", 32'(bus.ex_pc), 32'h0000_1234);
    chk("pt_br", 32'(bus.ex_br_flag), 32'd1);
    chk("pt_mem", 32'(bus.ex_mem_op), 32'd1);
    chk("pt_wr", bus.ex_mem_wr_data, 32'hCAFE_F00D);
    chk("pt_ctrl", 32'(bus.ex_ctrl_op), 32'd2);
    chk("pt_dst", 32'(bus.ex_dst_addr), 32'd17);
    alu("addu", ALU_OP_ADDU, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'd0, 1'b0);
    alu("subs_ovf", ALU_OP_SUBS, 32'h8000_0000, 32'd1,
        32'h7FFF_FFFF, 3'd3, 1'b1);
    alu("subs_ok", ALU_OP_SUBS, 32'd3, 32'd5, 32'hFFFF_FFFE, 3'd0, 1'b0);
    alu("subu", ALU_OP_SUBU, 32'd3, 32'd5, 32'hFFFF_FFFE, 3'd0, 1'b0);
    alu("and", ALU_OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F,
        32'h00F0_000F, 3'd0, 1'b0);
    alu("or", ALU_OP_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F,
        32'hFFF0_0FFF, 3'd0, 1'b0);
    alu("xor", ALU_OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F,
        32'hFF00_0FF0, 3'd0, 1'b0);
    alu("nop", ALU_OP_NOP, 32'h1234_5678, 32'd9, 32'd0, 3'd0, 1'b0);
    alu("shrl", ALU_OP_SHRL, 32'h8000_0000, 32'd33,
        32'h4000_0000, 3'd0, 1'b0);

    drive(ALU_OP_ADDS, 32'h7FFF_FFFF, 32'd1);
    bus.id_exp_code = 3'd5;
    tick;
    chk("upexp_exp", 32'(bus.ex_exp_code), 32'd5);
    chk("upexp_we", 32'(bus.ex_gpr_we_), 32'd0);

    drive(ALU_OP_ADDU, 32'd2, 32'd3);
    bus.id_en = 1'b0;
    #1;
    chk("noen_fwd", fwd, 32'd5);
    tick;
    chk("noen_en", 32'(bus.ex_en), 32'd0);
    chk("noen_we", 32'(bus.ex_gpr_we_), 32'd1);
    chk("noen_out", bus.ex_out, 32'd0);

    alu("pre_stall", ALU_OP_ADDU, 32'd40, 32'd2, 32'd42, 3'd0, 1'b0);
    drive(ALU_OP_ADDU, 32'd1, 32'd1);
    stall = 1'b1;
    tick;
    chk("stall_out", bus.ex_out, 32'd42);
    chk("stall_en", 32'(bus.ex_en), 32'd1);
    stall = 1'b0;
    tick;
    chk("unstall_out", bus.ex_out, 32'd2);
    stall = 1'b1;
    flush = 1'b1;
    tick;
    chk("flush_en", 32'(bus.ex_en), 32'd0);
    chk("flush_out", bus.ex_out, 32'd0);
    chk("flush_we", 32'(bus.ex_gpr_we_), 32'd1);
    stall = 1'b0;
    flush = 1'b0;

`ifdef EX_MDU_EN
    mdu("mul", ALU_OP_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    mdu("divu", ALU_OP_DIVU, 32'd100, 32'd7, 32'd14);
    mdu("remu", ALU_OP_REMU, 32'd100, 32'd7, 32'd2);
    mdu("divu0", ALU_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    mdu("remu0", ALU_OP_REMU, 32'd5, 32'd0, 32'd5);

    drive(ALU_OP_MUL, 32'd3, 32'd4);
    chk("mf_busy0", 32'(ex_busy), 32'd1);
    repeat (10) tick;
    chk("mf_busy10", 32'(ex_busy), 32'd1);
    chk("mf_bub10", 32'(bus.ex_en), 32'd0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    bus.id_en = 1'b0;
    #1;
    chk("mf_en", 32'(bus.ex_en), 32'd0);
    chk("mf_busy", 32'(ex_busy), 32'd0);
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.ex_en || ex_busy) en_cnt++;
    end
    chk("mf_never", 32'(en_cnt), 32'd0);

    drive(ALU_OP_DIVU, 32'd100, 32'd7);
    repeat (33) tick;
    chk("sd_busy33", 32'(ex_busy), 32'd0);
    stall = 1'b1;
    repeat (3) tick;
    chk("sd_hold_en", 32'(bus.ex_en), 32'd0);
    chk("sd_hold_busy", 32'(ex_busy), 32'd0);
    chk("sd_hold_fwd", fwd, 32'd14);
    stall = 1'b0;
    tick;
    chk("sd_out", bus.ex_out, 32'd14);
    chk("sd_en", 32'(bus.ex_en), 32'd1);
    bus.id_en = 1'b0;
    tick;

    drive(ALU_OP_MUL, 32'd6, 32'd7);
    repeat (5) tick;
    reset = 1'b1;
    bus.id_en = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    chk("mr_busy", 32'(ex_busy), 32'd0);
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.ex_en || ex_busy) en_cnt++;
    end
    chk("mr_never", 32'(en_cnt), 32'd0);
`else
    drive(ALU_OP_MUL, 32'h0001_0003, 32'd5);
    chk("um_busy0", 32'(ex_busy), 32'd0);
    tick;
    chk("um_exp", 32'(bus.ex_exp_code), 32'd2);
    chk("um_we", 32'(bus.ex_gpr_we_), 32'd1);
    chk("um_en", 32'(bus.ex_en), 32'd1);
    chk("um_busy1", 32'(ex_busy), 32'd0);
    drive(ALU_OP_REMU, 32'd100, 32'd7);
    bus.id_exp_code = 3'd1;
    tick;
    chk("ur_upexp", 32'(bus.ex_exp_code), 32'd1);
    chk("ur_we", 32'(bus.ex_gpr_we_), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
